// File: rtl/iobus_uart_pkg.sv
// rtl/iobus_uart_pkg.sv - shared types and register map for the IOBUS UART transmitter
package iobus_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
   localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
   localparam logic [31:0] CTRL_OFS   = 32'h0000_0008;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_COUNT = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-two depth
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   // full is the pre-edge value, so a push into a full FIFO is lost even if a pop frees a slot this edge
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/iobus_uart_tx.sv
// rtl/iobus_uart_tx.sv - IOBUS responder that queues bytes and sends them as 8N1 frames on TX
module iobus_uart_tx
   import iobus_uart_pkg::*;
#(
   parameter logic [31:0] BASE_AD      = 32'h1118_0000,
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] RD_DATA,
   output logic        TX
);

   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   logic             wr_data;
   logic             wr_ctrl;
   logic             ovf;
   logic             fifo_pop;
   logic [7:0]       fifo_rdata;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [31:0]      status;
   logic             unused_wdata;

   uart_tx_state_t    state_q, state_d;
   logic              tx_q, tx_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_q, bit_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic              baud_done;

   assign wr_data      = IOBUS_WR && (IOBUS_ADDR == BASE_AD + DATA_OFS);
   assign wr_ctrl      = IOBUS_WR && (IOBUS_ADDR == BASE_AD + CTRL_OFS);
   assign unused_wdata = ^IOBUS_OUT[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .push  (wr_data),
      .pop   (fifo_pop),
      .wdata (IOBUS_OUT[7:0]),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ovf <= 1'b0;
      end else if (wr_data && fifo_full) begin
         ovf <= 1'b1;
      end else if (wr_ctrl && IOBUS_OUT[0]) begin
         ovf <= 1'b0;
      end
   end

   always_comb begin
      status                     = '0;
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_BUSY]            = (state_q != IDLE);
      status[ST_OVF]             = ovf;
      status[ST_COUNT +: CNT_W]  = fifo_count;
      RD_DATA = (IOBUS_ADDR == BASE_AD + STATUS_OFS) ? status : 32'h0;
   end

   assign baud_done = (baud_q == BAUD_LAST);
   assign TX        = tx_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         shift_q <= '0;
         bit_q   <= '0;
         baud_q  <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         baud_q  <= baud_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      baud_d   = baud_q;
      fifo_pop = 1'b0;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               tx_d     = 1'b0;
               bit_d    = '0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_d = '0;
               // chain straight into the next start bit so queued bytes leave with no idle gap
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  tx_d     = 1'b0;
                  bit_d    = '0;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb/tb_iobus_uart_tx.sv - directed bench with a scoreboard of expected TX bytes
module tb_iobus_uart_tx;

   localparam int          CPB     = 4;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] BASE    = 32'h1118_0000;
   localparam logic [31:0] A_DATA  = BASE + 32'h0;
   localparam logic [31:0] A_STAT  = BASE + 32'h4;
   localparam logic [31:0] A_CTRL  = BASE + 32'h8;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] RD_DATA;
   logic        TX;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          frames_seen = 0;
   int          frames_expected = 0;
   logic [7:0]  exp_q[$];

   iobus_uart_tx #(
      .BASE_AD      (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .RD_DATA    (RD_DATA),
      .TX         (TX)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      IOBUS_ADDR = addr;
      IOBUS_OUT  = data;
      IOBUS_WR   = 1'b1;
      tick();
      IOBUS_WR   = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit accepted);
      bus_write(A_DATA, {24'h0, b});
      if (accepted) begin
         exp_q.push_back(b);
         frames_expected++;
      end
   endtask

   task automatic read_status(output logic [31:0] v);
      IOBUS_ADDR = A_STAT;
      #1;
      v = RD_DATA;
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      logic [31:0] s;
      read_status(s);
      check(tag, s, exp);
   endtask

   task automatic wait_idle(input int max_cycles);
      logic [31:0] s;
      for (int i = 0; i < max_cycles; i++) begin
         read_status(s);
         if (s === 32'h2) break;
         tick();
      end
      check_status("wait_idle", 32'h2);
   endtask

   // Capture each frame cycle by cycle; a frame interrupted by reset is discarded.
   initial begin : tx_monitor
      logic [10*CPB-1:0] line;
      logic [7:0]        got;
      logic              shape_ok;
      logic              aborted;
      forever begin
         @(negedge CLK);
         if (RST_N === 1'b1 && TX === 1'b0) begin
            line    = '0;
            line[0] = TX;
            aborted = 1'b0;
            for (int c = 1; c < 10*CPB; c++) begin
               @(negedge CLK);
               if (RST_N !== 1'b1) aborted = 1'b1;
               line[c] = TX;
            end
            if (!aborted) begin
               shape_ok = 1'b1;
               for (int b = 0; b < 10; b++)
                  for (int s = 1; s < CPB; s++)
                     if (line[b*CPB+s] !== line[b*CPB]) shape_ok = 1'b0;
               if (line[0] !== 1'b0 || line[9*CPB] !== 1'b1) shape_ok = 1'b0;
               for (int b = 0; b < 8; b++) got[b] = line[(b+1)*CPB];
               frames_seen++;
               check("frame_shape", {31'h0, shape_ok}, 32'h1);
               n_assert++;
               assert (exp_q.size() != 0) else begin
                  n_fail++;
                  $error("FAIL unexpected_frame observed=0x%0h expected=none", got);
               end
               if (exp_q.size() != 0) check("frame_byte", {24'h0, got}, {24'h0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin : stimulus
      int lows;

      RST_N      = 1'b0;
      IOBUS_WR   = 1'b0;
      IOBUS_ADDR = 32'h0;
      IOBUS_OUT  = 32'h0;
      repeat (3) tick();
      check("reset_tx", {31'h0, TX}, 32'h1);
      check_status("reset_status", 32'h2);
      RST_N = 1'b1;
      tick();
      check_status("post_reset_status", 32'h2);

      // single byte: TX falls one edge after the write, 40-cycle frame
      send(8'hA5, 1'b1);
      check("single_tx_before_pop", {31'h0, TX}, 32'h1);
      check_status("single_count1", 32'h10);
      tick();
      check("single_tx_start", {31'h0, TX}, 32'h0);
      check_status("single_busy", 32'h6);
      repeat (39) tick();
      check("single_stop_bit", {31'h0, TX}, 32'h1);
      check_status("single_busy_in_stop", 32'h6);
      tick();
      check_status("single_done", 32'h2);

      // back-to-back frames with zero gap
      send(8'h00, 1'b1);
      check_status("b2b_count_a", 32'h10);
      send(8'hFF, 1'b1);
      check_status("b2b_count_b", 32'h14);
      repeat (35) tick();
      check("b2b_last_data_low", {31'h0, TX}, 32'h0);
      repeat (4) tick();
      check("b2b_stop", {31'h0, TX}, 32'h1);
      tick();
      check("b2b_no_gap", {31'h0, TX}, 32'h0);
      check_status("b2b_second_busy", 32'h6);
      repeat (39) tick();
      check_status("b2b_second_stop", 32'h6);
      tick();
      check_status("b2b_done", 32'h2);

      // overflow: one in flight, four queued, sixth byte dropped
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b1);
      send(8'h44, 1'b1);
      send(8'h55, 1'b1);
      check_status("ovf_full", 32'h45);
      send(8'h66, 1'b0);
      check_status("ovf_set", 32'h4D);
      bus_write(A_STAT, 32'h77);
      check_status("ovf_status_write_ignored", 32'h4D);
      bus_write(A_CTRL, 32'h2);
      check_status("ovf_ctrl_bit1_ignored", 32'h4D);
      bus_write(A_CTRL, 32'h1);
      check_status("ovf_cleared", 32'h45);
      wait_idle(400);

      // push/pop collision at the STOP->START edge
      send(8'hC0, 1'b1);
      send(8'hC1, 1'b1);
      send(8'hC2, 1'b1);
      send(8'hC3, 1'b1);
      send(8'hC4, 1'b1);
      check_status("coll_full", 32'h45);
      repeat (36) tick();
      check_status("coll_full_pre_edge", 32'h45);
      check("coll_in_stop", {31'h0, TX}, 32'h1);
      send(8'hEE, 1'b0);
      check_status("coll_full_drop", 32'h3C);
      check("coll_next_start", {31'h0, TX}, 32'h0);
      bus_write(A_CTRL, 32'h1);
      check_status("coll_ovf_clear", 32'h34);
      repeat (38) tick();
      check_status("coll_count3", 32'h34);
      tick();
      check_status("coll_count2", 32'h24);
      repeat (39) tick();
      check_status("coll_count2_pre_edge", 32'h24);
      send(8'hC6, 1'b1);
      check_status("coll_count2_kept", 32'h24);
      wait_idle(400);

      // reset during data bit 3 of 0xA5 (bit3 = 0)
      send(8'hA5, 1'b0);
      repeat (18) tick();
      check("rst_bit3_low", {31'h0, TX}, 32'h0);
      RST_N = 1'b0;
      tick();
      check("rst_tx_high", {31'h0, TX}, 32'h1);
      check_status("rst_status", 32'h2);
      RST_N = 1'b1;
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (TX !== 1'b1) lows++;
      end
      check("rst_no_residual", lows, 0);
      check_status("rst_idle", 32'h2);

      check("frames_seen", frames_seen, frames_expected);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
